// File: rtl/decode.sv
`default_nettype none
// ============================================================================
//  Module   : decode
//  Purpose  : RV32I decode stage. Decodes at accept into a 2-entry in-order
//             buffer that presents its head entry to execute.
//  Revision : 1.0 - initial release
// ============================================================================
module decode #(
    parameter int ILL_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] f_instr_addr,
    input  logic [31:0] f_instr_dat,
    input  logic        f_v,
    input  logic        jmp_tk,
    output logic        d_rdy,
    input  logic        e_rdy,
    output logic        d_v,
    output logic [31:0] d_pc,
    output logic [6:0]  d_opc,
    output logic [2:0]  d_funct3,
    output logic        d_funct7b5,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [31:0] d_imm,
    output logic        d_illegal
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_two   = 2'd2;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_misc   = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } entry_t;

    logic [1:0] r_state;
    entry_t     r_head;
    entry_t     r_tail;
    entry_t     w_dec;
    logic       w_legal;
    logic       w_acc;
    logic       w_xfer;
    logic       w_i31;

    assign w_i31 = f_instr_dat[31];

    always_comb begin
        w_dec          = '0;
        w_legal        = (f_instr_dat[1:0] == 2'b11);
        w_dec.pc       = f_instr_addr;
        w_dec.opc      = f_instr_dat[6:0];
        w_dec.funct3   = f_instr_dat[14:12];
        w_dec.funct7b5 = f_instr_dat[30];
        w_dec.rd       = f_instr_dat[11:7];
        w_dec.rs1      = f_instr_dat[19:15];
        case (f_instr_dat[6:0])
            c_op_lui, c_op_auipc: begin
                w_dec.rs1 = 5'd0;
                w_dec.imm = {f_instr_dat[31:12], 12'b0};
            end
            c_op_jal: begin
                w_dec.rs1 = 5'd0;
                w_dec.imm = {{12{w_i31}}, f_instr_dat[19:12], f_instr_dat[20],
                             f_instr_dat[30:21], 1'b0};
            end
            c_op_jalr, c_op_load, c_op_opimm, c_op_misc, c_op_system: begin
                w_dec.imm = {{20{w_i31}}, f_instr_dat[31:20]};
            end
            c_op_branch: begin
                w_dec.rd  = 5'd0;
                w_dec.rs2 = f_instr_dat[24:20];
                w_dec.imm = {{20{w_i31}}, f_instr_dat[7], f_instr_dat[30:25],
                             f_instr_dat[11:8], 1'b0};
            end
            c_op_store: begin
                w_dec.rd  = 5'd0;
                w_dec.rs2 = f_instr_dat[24:20];
                w_dec.imm = {{20{w_i31}}, f_instr_dat[31:25], f_instr_dat[11:7]};
            end
            c_op_op: begin
                w_dec.rs2 = f_instr_dat[24:20];
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal words carry only the flag so nothing downstream acts on junk fields.
        if ((ILL_CHECK != 0) && !w_legal) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
    end

    // Ready comes from registered state (and reset) only, never from e_rdy.
    assign d_rdy  = ~rst & (r_state != c_st_two);
    assign d_v    = (r_state != c_st_empty);
    assign w_acc  = f_v & d_rdy;
    assign w_xfer = d_v & e_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_empty;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (jmp_tk) begin
            r_state <= c_st_empty;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_acc) begin
                        r_head  <= w_dec;
                        r_state <= c_st_one;
                    end
                end
                c_st_one: begin
                    case ({w_acc, w_xfer})
                        2'b10: begin
                            r_tail  <= w_dec;
                            r_state <= c_st_two;
                        end
                        2'b01:   r_state <= c_st_empty;
                        2'b11:   r_head  <= w_dec;
                        default: ;
                    endcase
                end
                c_st_two: begin
                    if (w_xfer) begin
                        r_head  <= r_tail;
                        r_state <= c_st_one;
                    end
                end
                default: r_state <= c_st_empty;
            endcase
        end
    end

    assign d_pc       = r_head.pc;
    assign d_opc      = r_head.opc;
    assign d_funct3   = r_head.funct3;
    assign d_funct7b5 = r_head.funct7b5;
    assign d_rd       = r_head.rd;
    assign d_rs1      = r_head.rs1;
    assign d_rs2      = r_head.rs2;
    assign d_imm      = r_head.imm;
    assign d_illegal  = r_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode
//  Purpose  : Self-checking bench for decode: vector table, corner sequences
//             and random traffic against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        ent_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] f_instr_addr = '0;
    logic [31:0] f_instr_dat = '0;
    logic        f_v = 1'b0;
    logic        jmp_tk = 1'b0;
    logic        e_rdy = 1'b0;

    logic        d_rdy, d_v, d_funct7b5, d_illegal;
    logic [31:0] d_pc, d_imm;
    logic [6:0]  d_opc;
    logic [2:0]  d_funct3;
    logic [4:0]  d_rd, d_rs1, d_rs2;

    logic        n_rdy, n_v, n_funct7b5, n_illegal;
    logic [31:0] n_pc, n_imm;
    logic [6:0]  n_opc;
    logic [2:0]  n_funct3;
    logic [4:0]  n_rd, n_rs1, n_rs2;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t qa[$];
    ent_t qb[$];
    vec_t vec[9];

    always #5 clk = ~clk;

    decode #(.ILL_CHECK(1)) u_dut (
        .clk(clk), .rst(rst), .f_instr_addr(f_instr_addr), .f_instr_dat(f_instr_dat),
        .f_v(f_v), .jmp_tk(jmp_tk), .d_rdy(d_rdy), .e_rdy(e_rdy), .d_v(d_v),
        .d_pc(d_pc), .d_opc(d_opc), .d_funct3(d_funct3), .d_funct7b5(d_funct7b5),
        .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_imm(d_imm), .d_illegal(d_illegal)
    );

    decode #(.ILL_CHECK(0)) u_dut_nc (
        .clk(clk), .rst(rst), .f_instr_addr(f_instr_addr), .f_instr_dat(f_instr_dat),
        .f_v(f_v), .jmp_tk(jmp_tk), .d_rdy(n_rdy), .e_rdy(e_rdy), .d_v(n_v),
        .d_pc(n_pc), .d_opc(n_opc), .d_funct3(n_funct3), .d_funct7b5(n_funct7b5),
        .d_rd(n_rd), .d_rs1(n_rs1), .d_rs2(n_rs2), .d_imm(n_imm), .d_illegal(n_illegal)
    );

    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        return v[w-1] ? v - (32'd1 << w) : v;
    endfunction

    // Reference decode straight from the ISA field rules.
    function automatic ent_t ref_decode(input logic [31:0] pc, input logic [31:0] ins,
                                        input bit chk);
        ent_t e;
        bit   legal = 1;
        e.pc = pc; e.opc = ins[6:0]; e.f3 = ins[14:12]; e.f7b5 = ins[30];
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = 5'd0; e.imm = 32'd0; e.ill = 1'b0;
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin e.rs1 = 0; e.imm = ins & 32'hFFFFF000; end
            7'b1101111: begin
                e.rs1 = 0;
                e.imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011:
                e.imm = sext(ins >> 20, 12);
            7'b1100011: begin
                e.rd = 0; e.rs2 = ins[24:20];
                e.imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            end
            7'b0100011: begin
                e.rd = 0; e.rs2 = ins[24:20];
                e.imm = sext({ins[31:25], ins[11:7]}, 12);
            end
            7'b0110011: e.rs2 = ins[24:20];
            default: legal = 0;
        endcase
        if (!legal && chk) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic ent_t pack_a();
        return {d_pc, d_opc, d_funct3, d_funct7b5, d_rd, d_rs1, d_rs2, d_imm, d_illegal};
    endfunction

    function automatic ent_t pack_b();
        return {n_pc, n_opc, n_funct3, n_funct7b5, n_rd, n_rs1, n_rs2, n_imm, n_illegal};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Buffer model: at most two entries, flush wins, ready only below two.
    task automatic model_edge();
        bit acc, xf;
        if (rst || jmp_tk) begin
            qa.delete();
            qb.delete();
        end else begin
            acc = f_v && (qa.size() < 2);
            xf  = e_rdy && (qa.size() > 0);
            if (xf) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc) begin
                qa.push_back(ref_decode(f_instr_addr, f_instr_dat, 1'b1));
                qb.push_back(ref_decode(f_instr_addr, f_instr_dat, 1'b0));
            end
        end
    endtask

    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic er, input logic jt);
        f_v = fv; f_instr_addr = pc; f_instr_dat = ins; e_rdy = er; jmp_tk = jt;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".d_v"}, 96'(d_v), 96'(qa.size() != 0));
        check({tag, ".d_rdy"}, 96'(d_rdy), 96'(!rst && qa.size() < 2));
        if (qa.size() != 0) check({tag, ".head"}, 96'(pack_a()), 96'(qa[0]));
        check({tag, ".nc_v"}, 96'(n_v), 96'(qb.size() != 0));
        if (qb.size() != 0) check({tag, ".nc_head"}, 96'(pack_b()), 96'(qb[0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".d_v"}, 96'(d_v), 96'(0));
        check({tag, ".d_rdy"}, 96'(d_rdy), 96'(0));
        check({tag, ".fields"}, 96'(pack_a()), 96'(0));
        check({tag, ".nc_fields"}, 96'(pack_b()), 96'(0));
    endtask

    logic [6:0] ops[12];

    initial begin
        vec[0] = '{32'h00500093, 32'h100, '{32'h100, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0}};
        vec[1] = '{32'hFE20AE23, 32'h104, '{32'h104, 7'b0100011, 3'b010, 1'b1, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0}};
        vec[2] = '{32'h008000EF, 32'h108, '{32'h108, 7'b1101111, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0}};
        vec[3] = '{32'h00000000, 32'h10C, '{32'h0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1}};
        vec[4] = '{32'h123450B7, 32'h110, '{32'h110, 7'b0110111, 3'd5, 1'b0, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0}};
        vec[5] = '{32'hFE208CE3, 32'h114, '{32'h114, 7'b1100011, 3'd0, 1'b1, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b0}};
        vec[6] = '{32'h002081B3, 32'h118, '{32'h118, 7'b0110011, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0}};
        vec[7] = '{32'h402081B3, 32'h11C, '{32'h11C, 7'b0110011, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0}};
        vec[8] = '{32'hFFFFFFFF, 32'h120, '{32'h0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1}};
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b0000000};

        #2;
        check_reset_outputs("reset");
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check_model("post_reset");

        // Decode table: accept into an empty buffer, inspect, then drain.
        foreach (vec[i]) begin
            step(1, vec[i].pc, vec[i].instr, 0, 0);
            check($sformatf("vec%0d.d_v", i), 96'(d_v), 96'(1));
            check($sformatf("vec%0d.fields", i), 96'(pack_a()), 96'(vec[i].exp));
            check($sformatf("vec%0d.nc_ill", i), 96'(n_illegal), 96'(0));
            check($sformatf("vec%0d.nc_pc", i), 96'(n_pc), 96'(vec[i].pc));
            check_model($sformatf("vec%0d", i));
            step(0, 0, 0, 1, 0);
            check_model($sformatf("vec%0d.drain", i));
        end

        // Back-to-back offers with execute stalled; the third is ignored.
        step(1, 32'h0, 32'h00500093, 0, 0);
        step(1, 32'h4, 32'h00500093, 0, 0);
        check("b2b.full_rdy", 96'(d_rdy), 96'(0));
        step(1, 32'h8, 32'h00500093, 0, 0);
        check("b2b.hold_pc", 96'(d_pc), 96'(32'h0));
        check_model("b2b.third");
        step(0, 0, 0, 1, 0);
        check("b2b.second_pc", 96'(d_pc), 96'(32'h4));
        step(0, 0, 0, 1, 0);
        check("b2b.empty_v", 96'(d_v), 96'(0));
        check("b2b.empty_rdy", 96'(d_rdy), 96'(1));

        // Flush while full with a simultaneous offer.
        step(1, 32'h20, 32'h00500093, 0, 0);
        step(1, 32'h24, 32'h00500093, 0, 0);
        step(1, 32'h28, 32'h00500093, 1, 1);
        check("flush.d_v", 96'(d_v), 96'(0));
        check("flush.d_rdy", 96'(d_rdy), 96'(1));
        step(0, 0, 0, 1, 0);
        check_model("flush.after");

        // Asynchronous reset between edges while holding one entry.
        step(1, 32'h200, 32'h00500093, 0, 0);
        check_model("arst.one");
        #3 rst = 1'b1;
        #1;
        qa.delete();
        qb.delete();
        check_reset_outputs("arst");
        #1 rst = 1'b0;
        step(0, 0, 0, 0, 0);
        check("arst.rdy_after", 96'(d_rdy), 96'(1));
        check_model("arst.after");

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ins;
            int k;
            k = $urandom_range(0, 11);
            ins = $urandom();
            ins[6:0] = (k == 11) ? 7'($urandom()) : ops[k];
            step(1'($urandom_range(0, 3) != 0), {$urandom(), 2'b00} & 32'hFFFFFFFF, ins,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have parameter ILL_CHECK, default 1: when 1, illegal-encoding detection is enabled; when 0, d_illegal is tied to 0.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port f_instr_addr  input  32  PC of the offered instruction, from fetch.
REQ-005 The block SHALL have port f_instr_dat  input  32  instruction word, from fetch.
REQ-006 The block SHALL have port f_v  input  1  offered instruction valid (driven as the inverse of the fetch stall).
REQ-007 The block SHALL have port jmp_tk  input  1  taken-jump flush, from writeback.
REQ-008 The block SHALL have port d_rdy  output  1  decode can accept an instruction this cycle.
REQ-009 The block SHALL have port e_rdy  input  1  execute accepts the head entry this cycle.
REQ-010 The block SHALL have port d_v  output  1  head entry valid.
REQ-011 The block SHALL have the following head-entry fields as outputs: d_pc 32; d_opc 7; d_funct3 3; d_funct7b5 1; d_rd 5; d_rs1 5; d_rs2 5; d_imm 32; d_illegal 1.

Function
REQ-012 Accept SHALL occur on a rising edge when f_v & d_rdy & ~jmp_tk; a transfer to execute SHALL occur when d_v & e_rdy.
REQ-013 The block SHALL hold decoded entries in a 2-entry in-order buffer with states EMPTY, ONE and TWO; d_v SHALL be 0 only in EMPTY.
REQ-014 d_rdy SHALL be 0 in TWO or while rst is high, and SHALL be 1 otherwise; it SHALL be derived from registered state only, with no combinational path from e_rdy.
REQ-015 The state transitions SHALL be:
- EMPTY to ONE on accept.
- ONE to TWO on accept without transfer.
- ONE to EMPTY on transfer without accept.
- ONE stays ONE on simultaneous accept and transfer, with the new entry becoming head next cycle.
- TWO to ONE on transfer.
REQ-016 An input offered while d_rdy=0 SHALL be ignored and SHALL leave state unchanged.
REQ-017 Decode SHALL occur at accept, with decoded fields stored in the buffer; an instruction accepted at edge N SHALL be visible on d_v/d_* from edge N when the buffer is empty (1-cycle latency).
REQ-018 While d_v=1 and e_rdy=0, all d_* outputs SHALL remain stable.
REQ-019 jmp_tk=1 at an edge SHALL force EMPTY, SHALL drop any same-cycle input, and SHALL take priority over accept and transfer; d_v SHALL be 0 in the following cycle.
REQ-020 Field extraction SHALL be: d_opc=instr[6:0], d_funct3=instr[14:12], d_funct7b5=instr[30].
REQ-021 d_rd SHALL be instr[11:7], except 0 for STORE and BRANCH.
REQ-022 d_rs1 SHALL be instr[19:15], except 0 for LUI, AUIPC and JAL.
REQ-023 d_rs2 SHALL be instr[24:20] for OP, STORE and BRANCH, and 0 otherwise.
REQ-024 d_imm SHALL be sign-extended from instr[31]:
- I-type (LOAD, OP-IMM, JALR, SYSTEM, MISC-MEM): instr[31:20].
- S-type: {instr[31:25], instr[11:7]}.
- B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type: {instr[31:12], 12'b0}.
- J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- OP: 0.
REQ-025 d_illegal SHALL be 1 when instr[1:0]!=2'b11 or when d_opc is not one of 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
REQ-026 Illegal entries SHALL still flow through the buffer with d_illegal=1, and all other d_* fields SHALL then be 0.

Reset
REQ-027 While rst is high: state EMPTY, d_v=0, d_rdy=0, and all d_* data outputs 0.
REQ-028 Reset mid-operation SHALL discard all buffered entries immediately and asynchronously; d_rdy=1 SHALL hold from the first cycle after rst deasserts.

Verification
REQ-029 Scenario: f_v=1, f_instr_dat=0x00500093, pc=0x100, e_rdy=1 -> next cycle d_v=1, d_pc=0x100, d_opc=0010011, d_rd=1, d_rs1=0, d_rs2=0, d_imm=5, d_illegal=0.
REQ-030 Scenario: f_instr_dat=0xFE20AE23 (sw x2,-4(x1)) -> d_rd=0, d_rs1=1, d_rs2=2, d_funct3=010, d_imm=0xFFFFFFFC; f_instr_dat=0x008000EF (jal x1,+8) -> d_rd=1, d_rs1=0, d_imm=8.
REQ-031 Scenario: e_rdy=0, three back-to-back f_v=1 at pc 0x0/0x4/0x8 -> state TWO after the 2nd, d_rdy=0, 3rd ignored; e_rdy=1 for 2 cycles -> d_pc 0x0 then 0x4, then d_v=0, d_rdy=1.
REQ-032 Scenario: state TWO with f_v=1 and jmp_tk=1 at the same edge -> next cycle d_v=0, d_rdy=1, no entry from that cycle ever appears.
REQ-033 Scenario: f_instr_dat=0x00000000 -> d_v=1, d_illegal=1, other d_* fields 0; repeat with ILL_CHECK=0 -> d_illegal=0.
REQ-034 Scenario: rst pulsed asynchronously (between clock edges) while in state ONE -> d_v=0 immediately, all d_* outputs 0, d_rdy=1 the cycle after release.
